// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-boundary widths, ID/EX control field offsets and stage-register FSM encodings
package pipe_pkg;
  localparam int IDEX_CTRL_W = 11;
  localparam int IDEX_DATA_W = 84;
  localparam int IFID_CTRL_W = 1;
  localparam int IFID_DATA_W = 64;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;
  localparam int IDEX_ALUOP_LSB = 0;
  localparam int IDEX_ALUOP_MSB = 2;
  localparam int IDEX_REGWRITE = 3;
  localparam int IDEX_MEMTOREG = 4;
  localparam int IDEX_MEM_WEN = 5;
  localparam int IDEX_MEM_REN = 6;
  localparam int IDEX_REGDST = 7;
  localparam int IDEX_ALUSRC = 8;
  localparam int IDEX_SHIFT = 9;
  localparam int IDEX_PC_JUMP = 10;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_TWO = 2'd2;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+ctrl+data slot; clearing drops valid and zeroes ctrl but keeps data
module pipe_entry #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 84
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      valid <= 1'b0;
      ctrl <= '0;
      data <= '0;
    end else if (ld) begin
      valid <= 1'b1;
      ctrl <= d_ctrl;
      data <= d_data;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl <= '0;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline register with valid/ready, flush, bubbles and optional two-entry skid
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter bit SKID = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic [1:0] state_q, state_d;
  logic rdy_q, accept, pop, head_ld, head_clr, skid_ld, skid_clr, skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, head_ctrl_d;
  logic [DATA_W-1:0] skid_data, head_data_d;
  assign in_ready = !flush & (SKID ? rdy_q : (!out_valid | out_ready));
  assign accept = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign occupancy = state_q;
  // With SKID=0 an accept in ONE always coincides with a pop, so TWO is unreachable
  always_comb begin
    head_ld = !flush & ((state_q == ST_TWO) ? pop : accept & ((state_q == ST_EMPTY) | pop));
    head_clr = flush | (pop & !head_ld);
    skid_ld = !flush & (state_q == ST_ONE) & accept & !pop;
    skid_clr = flush | ((state_q == ST_TWO) & pop);
    head_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
    head_data_d = skid_valid ? skid_data : in_data;
    state_d = flush ? ST_EMPTY :
              (state_q == ST_EMPTY) ? (accept ? ST_ONE : ST_EMPTY) :
              (state_q == ST_ONE) ? (skid_ld ? ST_TWO : (pop & !accept) ? ST_EMPTY : ST_ONE) :
              (pop ? ST_ONE : ST_TWO);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q <= state_d != ST_TWO;
    end
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clock(clock), .reset(reset), .ld(head_ld), .clr(head_clr),
    .d_ctrl(head_ctrl_d), .d_data(head_data_d),
    .valid(out_valid), .ctrl(out_ctrl), .data(out_data)
  );
  if (SKID) begin : g_skid
    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clock(clock), .reset(reset), .ld(skid_ld), .clr(skid_clr),
      .d_ctrl(in_ctrl), .d_data(in_data),
      .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
    );
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end
endmodule
